aq_gemac_mii_rx_check: RTL and testbench

MII receive-side frame checker for the GEMAC echo path. It sits on the EMAC RX pins, directly downstream of the echo MAC's transmit output when the bench loops TXD back to RXD. It strips preamble/SFD, assembles nibbles into bytes and re-emits them as a byte stream. It checks length, alignment, RX_ER and FCS, and keeps saturating good/bad frame counters for LEDs and self-test.

---
 rtl/aq_gemac_mii_rx_check.sv | 217 +++++++++++++++++++++
 tb/tb_aq_gemac_mii_rx_check.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aq_gemac_mii_rx_check.sv
// MII receive frame checker: strips preamble/SFD, rebuilds bytes from nibbles,
// and reports CRC, length, odd-nibble and RX_ER status per frame with saturating counters.
module aq_gemac_mii_rx_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        EMAC_RX_CLK,
  input  logic        RESET,
  input  logic [3:0]  EMAC_RXD_I,
  input  logic        EMAC_RX_DV,
  input  logic        EMAC_RX_ER,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  output logic        RX_SOF,
  output logic        FRAME_DONE,
  output logic        FRAME_OK,
  output logic [15:0] FRAME_LEN,
  output logic [3:0]  ERR_FLAGS,
  output logic [15:0] GOOD_CNT,
  output logic [15:0] BAD_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic        dv_q, dv_d, er_q, er_d;
  logic [3:0]  rxd_q, rxd_d, low_nib_q, low_nib_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        phase_q, phase_d, er_seen_q, er_seen_d, sof_pend_q, sof_pend_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d, rx_sof_q, rx_sof_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [15:0] frame_len_q, frame_len_d, good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [3:0]  err_flags_q, err_flags_d, flags_s;
  logic [7:0]  byte_s;
  logic        len_bad_s, crc_bad_s;

  always_comb begin
    dv_d         = EMAC_RX_DV;
    er_d         = EMAC_RX_ER;
    rxd_d        = EMAC_RXD_I;
    state_d      = state_q;
    low_nib_d    = low_nib_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    phase_d      = phase_q;
    er_seen_d    = er_seen_q;
    sof_pend_d   = sof_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_sof_d     = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_len_d  = frame_len_q;
    err_flags_d  = err_flags_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    byte_s       = {rxd_q, low_nib_q};
    len_bad_s    = (byte_cnt_q < 16'(MIN_LEN)) || (byte_cnt_q > 16'(MAX_LEN));
    // The register shifts right (reflected), so the residue is compared bit-reversed.
    crc_bad_s    = (bit_rev32(crc_q) != CRC_RESIDUE);
    flags_s      = {er_seen_q, phase_q, len_bad_s, crc_bad_s};

    case (state_q)
      ST_IDLE: begin
        if (dv_q) begin
          state_d = (rxd_q == 4'h5) ? ST_PREAMBLE : ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (rxd_q == 4'h5) begin
          state_d = ST_PREAMBLE;
        end else if (rxd_q == 4'hD) begin
          state_d    = ST_DATA;
          crc_d      = CRC_INIT;
          byte_cnt_d = 16'd0;
          phase_d    = 1'b0;
          er_seen_d  = 1'b0;
          sof_pend_d = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!dv_q) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          frame_ok_d   = (flags_s == 4'd0);
          frame_len_d  = byte_cnt_q;
          err_flags_d  = flags_s;
          if (flags_s == 4'd0) begin
            good_cnt_d = sat_inc16(good_cnt_q);
          end else begin
            bad_cnt_d = sat_inc16(bad_cnt_q);
          end
        end else begin
          if (er_q) begin
            er_seen_d = 1'b1;
          end else begin
            er_seen_d = er_seen_q;
          end
          if (!phase_q) begin
            low_nib_d = rxd_q;
            phase_d   = 1'b1;
          end else begin
            rx_data_d  = byte_s;
            rx_valid_d = 1'b1;
            rx_sof_d   = sof_pend_q;
            sof_pend_d = 1'b0;
            crc_d      = crc32_byte(crc_q, byte_s);
            byte_cnt_d = sat_inc16(byte_cnt_q);
            phase_d    = 1'b0;
          end
        end
      end
      ST_DROP: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge EMAC_RX_CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      dv_q         <= 1'b0;
      er_q         <= 1'b0;
      rxd_q        <= 4'd0;
      low_nib_q    <= 4'd0;
      crc_q        <= CRC_INIT;
      byte_cnt_q   <= 16'd0;
      phase_q      <= 1'b0;
      er_seen_q    <= 1'b0;
      sof_pend_q   <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= 16'd0;
      err_flags_q  <= 4'd0;
      good_cnt_q   <= 16'd0;
      bad_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      dv_q         <= dv_d;
      er_q         <= er_d;
      rxd_q        <= rxd_d;
      low_nib_q    <= low_nib_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      phase_q      <= phase_d;
      er_seen_q    <= er_seen_d;
      sof_pend_q   <= sof_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sof_q     <= rx_sof_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_len_q  <= frame_len_d;
      err_flags_q  <= err_flags_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign RX_DATA    = rx_data_q;
  assign RX_VALID   = rx_valid_q;
  assign RX_SOF     = rx_sof_q;
  assign FRAME_DONE = frame_done_q;
  assign FRAME_OK   = frame_ok_q;
  assign FRAME_LEN  = frame_len_q;
  assign ERR_FLAGS  = err_flags_q;
  assign GOOD_CNT   = good_cnt_q;
  assign BAD_CNT    = bad_cnt_q;

endmodule

// File: tb/tb_aq_gemac_mii_rx_check.sv
// Scoreboard bench for aq_gemac_mii_rx_check: frames are built in the bench, expected
// bytes and frame status are queued at issue time and checked by an independent monitor.
module tb_aq_gemac_mii_rx_check;

  logic        clk = 1'b0;
  logic        rst, dv, er;
  logic [3:0]  rxd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, frame_done, frame_ok;
  logic [15:0] frame_len, good_cnt, bad_cnt;
  logic [3:0]  err_flags;

  always #20 clk = ~clk;

  aq_gemac_mii_rx_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .EMAC_RX_CLK(clk), .RESET(rst), .EMAC_RXD_I(rxd), .EMAC_RX_DV(dv), .EMAC_RX_ER(er),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_SOF(rx_sof), .FRAME_DONE(frame_done),
    .FRAME_OK(frame_ok), .FRAME_LEN(frame_len), .ERR_FLAGS(err_flags),
    .GOOD_CNT(good_cnt), .BAD_CNT(bad_cnt)
  );

  typedef struct packed {
    logic        ok;
    logic [15:0] len;
    logic [3:0]  flags;
    logic [15:0] good;
    logic [15:0] bad;
  } status_t;

  status_t    exp_st_q[$];
  logic [8:0] exp_byte_q[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         good_m = 0;
  int         bad_m  = 0;
  logic       prev_valid = 1'b0;
  logic [8:0] mon_b;
  status_t    mon_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ethernet FCS of frm[0..m-1], computed one bit at a time.
  function automatic logic [31:0] calc_fcs(input int m);
    logic [31:0] crc = 32'hFFFF_FFFF;
    logic        fb;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb  = crc[0] ^ frm[i][j];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB8_8320;
      end
    end
    return ~crc;
  endfunction

  task automatic make_frame(input int total_len);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < total_len - 4; i++) frm.push_back(8'($urandom));
    fcs = calc_fcs(total_len - 4);
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  task automatic drive(input logic d, input logic [3:0] n, input logic e);
    @(negedge clk);
    dv = d; rxd = n; er = e;
  endtask

  task automatic send_frame(input int npre, input logic bad_pre, input logic extra_nib,
                            input int er_at, input logic er_pre, input int reset_at, input int ifg);
    int          n = frm.size();
    status_t     s;
    logic [31:0] fcs_rx;
    if (!bad_pre) begin
      for (int i = 0; i < n; i++) begin
        if (reset_at < 0 || i < reset_at - 1) exp_byte_q.push_back({(i == 0), frm[i]});
      end
      if (reset_at < 0) begin
        fcs_rx     = (n >= 4) ? {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} : 32'd0;
        s.flags[0] = (n < 4) || (calc_fcs(n - 4) != fcs_rx);
        s.flags[1] = (n < 64) || (n > 1518);
        s.flags[2] = extra_nib;
        s.flags[3] = (er_at >= 0) && (er_at < n);
        s.ok       = (s.flags == 4'd0);
        s.len      = 16'(n);
        if (s.ok) good_m = (good_m < 65535) ? good_m + 1 : good_m;
        else      bad_m  = (bad_m < 65535) ? bad_m + 1 : bad_m;
        s.good = 16'(good_m);
        s.bad  = 16'(bad_m);
        exp_st_q.push_back(s);
      end
    end
    for (int p = 0; p < npre; p++) drive(1'b1, 4'h5, er_pre && (p == 0));
    if (bad_pre) begin
      drive(1'b1, 4'h7, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 4'($urandom), 1'b0);
    end else begin
      drive(1'b1, 4'hD, 1'b0);
      for (int i = 0; i < n; i++) begin
        if (i == reset_at) begin
          @(negedge clk);
          rst = 1'b1; dv = 1'b1; rxd = frm[i][3:0]; er = 1'b0;
          @(negedge clk);
          rst = 1'b0; rxd = 4'hA;
          check("rst_rx_valid", rx_valid, 0);
          check("rst_rx_data", rx_data, 0);
          check("rst_frame_done", frame_done, 0);
          check("rst_frame_ok", frame_ok, 0);
          check("rst_frame_len", frame_len, 0);
          check("rst_err_flags", err_flags, 0);
          check("rst_good_cnt", good_cnt, 0);
          check("rst_bad_cnt", bad_cnt, 0);
          good_m = 0;
          bad_m  = 0;
          drive(1'b1, 4'hA, 1'b0);
          drive(1'b1, 4'hA, 1'b0);
          break;
        end
        drive(1'b1, frm[i][3:0], (i == er_at));
        drive(1'b1, frm[i][7:4], 1'b0);
      end
      if (extra_nib && reset_at < 0) drive(1'b1, 4'($urandom), 1'b0);
    end
    for (int i = 0; i < ifg; i++) drive(1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a frame status.
  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_valid_spacing", prev_valid, 0);
      if (exp_byte_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %02h expected none", rx_data);
      end else begin
        mon_b = exp_byte_q.pop_front();
        check("rx_data", rx_data, mon_b[7:0]);
        check("rx_sof", rx_sof, mon_b[8]);
      end
    end
    prev_valid = rx_valid;
    if (frame_done) begin
      if (exp_st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame_done: got len %0d expected none", frame_len);
      end else begin
        mon_s = exp_st_q.pop_front();
        check("frame_ok", frame_ok, mon_s.ok);
        check("frame_len", frame_len, mon_s.len);
        check("err_flags", err_flags, mon_s.flags);
        check("good_cnt", good_cnt, mon_s.good);
        check("bad_cnt", bad_cnt, mon_s.bad);
      end
    end
  end

  initial begin
    int len;
    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_good_cnt", good_cnt, 0);
    check("reset_bad_cnt", bad_cnt, 0);
    check("reset_frame_len", frame_len, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    make_frame(64); send_frame(15, 0, 0, -1, 0, -1, 4);
    make_frame(64); frm[10] = frm[10] ^ 8'h01; send_frame(15, 0, 0, -1, 0, -1, 4);
    make_frame(64); send_frame(7, 0, 0, 30, 0, -1, 4);
    make_frame(60); send_frame(7, 0, 0, -1, 0, -1, 4);
    make_frame(64); send_frame(7, 0, 1, -1, 0, -1, 4);
    make_frame(64); send_frame(3, 1, 0, -1, 0, -1, 1);
    make_frame(64); send_frame(1, 0, 0, -1, 0, -1, 1);
    make_frame(64); send_frame(1, 0, 0, -1, 0, -1, 1);
    make_frame(65); send_frame(4, 0, 0, -1, 1, -1, 3);
    make_frame(1518); send_frame(7, 0, 0, -1, 0, -1, 3);
    make_frame(1519); send_frame(7, 0, 0, -1, 0, -1, 3);
    make_frame(64); send_frame(7, 0, 0, -1, 0, 30, 4);
    make_frame(64); send_frame(7, 0, 0, -1, 0, -1, 2);
    make_frame(70); send_frame(7, 0, 0, -1, 0, -1, 2);

    for (int k = 0; k < 12; k++) begin
      len = 58 + int'($urandom_range(0, 32));
      make_frame(len);
      if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, len - 1)] ^= 8'(1 << $urandom_range(0, 7));
      send_frame(int'($urandom_range(1, 15)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                 1'($urandom_range(0, 1)), -1, int'($urandom_range(1, 4)));
    end

    for (int t = 0; t < 200 && (exp_st_q.size() != 0 || exp_byte_q.size() != 0); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("pending_bytes", exp_byte_q.size(), 0);
    check("pending_frames", exp_st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
